// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing constants for the register-file write-port control slice.
// Also holds the modulo-wrap helper used by the round-robin arbiter.
package regfile_ctrl_pkg;

    localparam int ADDSIZE  = 5;
    localparam int REGWIDTH = 32;
    localparam int REGSIZE  = 32;
    localparam int NREQ     = 3;

    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward with wrap,
// and the pointer value that follows the winner.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt
);

    // first requester at or after ptr wins; pointer moves just past it
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        nxt   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = rr_wrap(int'(ptr) + k, N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = PW'(rr_wrap(idx + 1, N));
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback sources and
// tracks outstanding destination writes for RAW hazard detection.
module regfile_wr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ     = regfile_ctrl_pkg::NREQ,
    parameter int ADDSIZE  = regfile_ctrl_pkg::ADDSIZE,
    parameter int REGWIDTH = regfile_ctrl_pkg::REGWIDTH,
    parameter int REGSIZE  = regfile_ctrl_pkg::REGSIZE
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*ADDSIZE-1:0]  ReqRW,
    input  logic [NREQ*REGWIDTH-1:0] ReqBusW,
    output logic [NREQ-1:0]          Gnt,
    output logic [ADDSIZE-1:0]       RW,
    output logic [REGWIDTH-1:0]      BusW,
    output logic                     RegWr,
    input  logic                     Rsv,
    input  logic [ADDSIZE-1:0]       RsvRW,
    input  logic [ADDSIZE-1:0]       RA,
    input  logic [ADDSIZE-1:0]       RB,
    output logic                     HazA,
    output logic                     HazB,
    output logic [REGSIZE-1:0]       Pending,
    output logic                     RsvErr
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_nxt;
    logic [ADDSIZE-1:0]  sel_rw;
    logic [REGWIDTH-1:0] sel_busw;
    logic [REGSIZE-1:0]  pend_nxt;
    logic                err_hit;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req (Req),
        .ptr (ptr),
        .gnt (Gnt),
        .nxt (ptr_nxt)
    );

    // route the granted requester's address and data to the write stage
    always_comb begin
        sel_rw   = '0;
        sel_busw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (Gnt[i]) begin
                sel_rw   = ReqRW[i*ADDSIZE +: ADDSIZE];
                sel_busw = ReqBusW[i*REGWIDTH +: REGWIDTH];
            end
        end
    end

    // register the winning write; r0 writes are consumed but never enabled
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr   <= '0;
            RW    <= '0;
            BusW  <= '0;
            RegWr <= 1'b0;
        end else begin
            RegWr <= 1'b0;
            if (|Gnt) begin
                ptr   <= ptr_nxt;
                RW    <= sel_rw;
                BusW  <= sel_busw;
                RegWr <= (sel_rw != '0);
            end
        end
    end

    // commit clears, reservation sets; a same-cycle set beats the clear
    always_comb begin
        pend_nxt = Pending;
        err_hit  = 1'b0;
        if (RegWr) begin
            pend_nxt[RW] = 1'b0;
        end
        if (Rsv && (RsvRW != '0)) begin
            if (Pending[RsvRW] && !(RegWr && (RW == RsvRW))) begin
                err_hit = 1'b1;
            end
            pend_nxt[RsvRW] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // scoreboard state and sticky double-reservation flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Pending <= '0;
            RsvErr  <= 1'b0;
        end else begin
            Pending <= pend_nxt;
            RsvErr  <= RsvErr | err_hit;
        end
    end

    assign HazA = Pending[RA];
    assign HazB = Pending[RB];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: stimulus queues expected
// grants and writes, a negedge monitor pops and compares them.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int RS   = 32;

    logic                 Clk;
    logic                 Rst_n;
    logic [NREQ-1:0]      Req;
    logic [NREQ*AW-1:0]   ReqRW;
    logic [NREQ*DW-1:0]   ReqBusW;
    logic [NREQ-1:0]      Gnt;
    logic [AW-1:0]        RW;
    logic [DW-1:0]        BusW;
    logic                 RegWr;
    logic                 Rsv;
    logic [AW-1:0]        RsvRW;
    logic [AW-1:0]        RA;
    logic [AW-1:0]        RB;
    logic                 HazA;
    logic                 HazB;
    logic [RS-1:0]        Pending;
    logic                 RsvErr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NREQ-1:0]   exp_gnt_q[$];
    logic [AW+DW-1:0]  exp_wr_q[$];

    regfile_wr_arbiter dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Req     (Req),
        .ReqRW   (ReqRW),
        .ReqBusW (ReqBusW),
        .Gnt     (Gnt),
        .RW      (RW),
        .BusW    (BusW),
        .RegWr   (RegWr),
        .Rsv     (Rsv),
        .RsvRW   (RsvRW),
        .RA      (RA),
        .RB      (RB),
        .HazA    (HazA),
        .HazB    (HazB),
        .Pending (Pending),
        .RsvErr  (RsvErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        ReqRW[i*AW +: AW]   = a;
        ReqBusW[i*DW +: DW] = d;
    endtask

    // monitor: compare grants and committed writes against queued expectations
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Req != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    check("gnt_unexpected", 64'(Gnt), 64'hFFFF);
                end else begin
                    check("gnt", 64'(Gnt), 64'(exp_gnt_q.pop_front()));
                end
            end else begin
                check("gnt_idle", 64'(Gnt), 64'h0);
            end
            if (RegWr) begin
                if (exp_wr_q.size() == 0) begin
                    check("regwr_unexpected", 64'({RW, BusW}), 64'hFFFF_FFFF_FFFF);
                end else begin
                    check("write", 64'({RW, BusW}), 64'(exp_wr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        Rst_n   = 1'b0;
        Req     = '0;
        ReqRW   = '0;
        ReqBusW = '0;
        Rsv     = 1'b0;
        RsvRW   = '0;
        RA      = '0;
        RB      = '0;
        step();
        step();
        check("rst_regwr", 64'(RegWr), 64'h0);
        check("rst_pending", 64'(Pending), 64'h0);
        check("rst_rsverr", 64'(RsvErr), 64'h0);
        check("rst_rw", 64'(RW), 64'h0);
        Rst_n = 1'b1;
        step();

        // reset mid-stream: build state, then drop reset during a commit
        Rsv = 1'b1; RsvRW = 5'd3;
        step();
        Req = 3'b001; set_slot(0, 5'd9, 32'h99);
        exp_gnt_q.push_back(3'b001);
        step();
        Req = '0; Rsv = 1'b0;
        check("pre_rst_regwr", 64'(RegWr), 64'h1);
        check("pre_rst_rsverr", 64'(RsvErr), 64'h1);
        check("pre_rst_pend3", 64'(Pending[3]), 64'h1);
        #1 Rst_n = 1'b0;
        #1;
        check("async_rst_regwr", 64'(RegWr), 64'h0);
        check("async_rst_pending", 64'(Pending), 64'h0);
        check("async_rst_rsverr", 64'(RsvErr), 64'h0);
        step();
        Rst_n = 1'b1;
        step();

        // single request, one-cycle write pulse
        Req = 3'b001; set_slot(0, 5'd5, 32'hDEADBEEF);
        exp_gnt_q.push_back(3'b001);
        exp_wr_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        Req = '0;
        step();
        step();
        check("single_pulse_end", 64'(RegWr), 64'h0);

        // contention from reset-time pointer 0
        Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
        step();
        Req = 3'b111;
        set_slot(0, 5'd10, 32'hA0);
        set_slot(1, 5'd11, 32'hA1);
        set_slot(2, 5'd12, 32'hA2);
        exp_gnt_q.push_back(3'b001);
        exp_gnt_q.push_back(3'b010);
        exp_gnt_q.push_back(3'b100);
        exp_wr_q.push_back({5'd10, 32'hA0});
        exp_wr_q.push_back({5'd11, 32'hA1});
        exp_wr_q.push_back({5'd12, 32'hA2});
        step();
        step();
        step();
        Req = 3'b101;
        exp_gnt_q.push_back(3'b001);
        exp_wr_q.push_back({5'd10, 32'hA0});
        step();
        Req = '0;
        step();

        // r0 write is granted but never enabled
        Req = 3'b010; set_slot(1, 5'd0, 32'h1234);
        exp_gnt_q.push_back(3'b010);
        step();
        Req = '0;
        step();
        check("r0_regwr", 64'(RegWr), 64'h0);
        check("r0_pending", 64'(Pending), 64'h0);

        // reservation of r0 ignored
        Rsv = 1'b1; RsvRW = 5'd0;
        step();
        Rsv = 1'b0;
        check("rsv_r0_pending", 64'(Pending), 64'h0);
        check("rsv_r0_err", 64'(RsvErr), 64'h0);

        // hazard through commit cycle
        RA = 5'd7; RB = 5'd7;
        Rsv = 1'b1; RsvRW = 5'd7;
        step();
        Rsv = 1'b0;
        check("haz_a_rsv", 64'(HazA), 64'h1);
        check("haz_b_rsv", 64'(HazB), 64'h1);
        Req = 3'b001; set_slot(0, 5'd7, 32'h77);
        exp_gnt_q.push_back(3'b001);
        exp_wr_q.push_back({5'd7, 32'h77});
        step();
        Req = '0;
        check("haz_a_commit", 64'(HazA), 64'h1);
        step();
        check("haz_a_after", 64'(HazA), 64'h0);
        check("pend_after", 64'(Pending), 64'h0);

        // set/clear collision, then a real double reservation
        Rsv = 1'b1; RsvRW = 5'd7;
        step();
        Rsv = 1'b0;
        Req = 3'b100; set_slot(2, 5'd7, 32'h700);
        exp_gnt_q.push_back(3'b100);
        exp_wr_q.push_back({5'd7, 32'h700});
        step();
        Req = '0;
        Rsv = 1'b1; RsvRW = 5'd7;
        step();
        Rsv = 1'b0;
        check("collide_pend7", 64'(Pending[7]), 64'h1);
        check("collide_err", 64'(RsvErr), 64'h0);
        Rsv = 1'b1; RsvRW = 5'd7;
        step();
        Rsv = 1'b0;
        check("double_rsv_err", 64'(RsvErr), 64'h1);
        check("double_rsv_pend", 64'(Pending), 64'h80);
        step();
        check("rsverr_sticky", 64'(RsvErr), 64'h1);

        step();
        step();
        check("gnt_q_drained", 64'(exp_gnt_q.size()), 64'h0);
        check("wr_q_drained", 64'(exp_wr_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
